// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-bundle input channel and instruction-word output
// channel of the instruction encoder.
//   master : producer of field bundles / consumer of encoded words
//   slave  : the encoder
// Input channel : in_valid/in_ready, fmt, opcode, funct3, funct7, rs1, rs2,
//                 rd, immed[N-1:0]
// Output channel: out_valid/out_ready, out_instr[31:0], out_addr[ADDR_W-1:0]
interface instr_encoder_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [4:0]        rd;
  logic [N-1:0]      immed;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, fmt, opcode, funct3, funct7, rs1, rs2, rd, immed, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, fmt, opcode, funct3, funct7, rs1, rs2, rd, immed, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into a 32-bit instruction word,
// queues it in a small FIFO and streams it out with an auto-incrementing
// byte address.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   clear      : synchronous flush (FIFO empty, address back to BASE_ADDR)
//   bus        : instr_encoder_if.slave (field input / word output channels)
//   err_imm    : sticky immediate range error, only with ENC_IMM_CHECK_EN
// Optional feature macro: ENC_IMM_CHECK_EN (immediate range checking).
// The interface ADDR_W must match the module ADDR_W.
module instr_encoder #(
  parameter int N          = 32,
  parameter int ADDR_W     = 10,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  instr_encoder_if.slave  bus
`ifdef ENC_IMM_CHECK_EN
  ,
  output logic            err_imm
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_ISH = 3'd2;
  localparam logic [2:0] FMT_S   = 3'd3;
  localparam logic [2:0] FMT_B   = 3'd4;
  localparam logic [2:0] FMT_U   = 3'd5;
  localparam logic [2:0] FMT_J   = 3'd6;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic [N-1:0]      imm;
  logic [31:0]       enc_word;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [31:0]       mem_d [FIFO_DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              empty, full, push, pop;

  assign imm = bus.immed;

  always_comb begin
    enc_word = NOP_WORD;
    case (bus.fmt)
      FMT_R:   enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      FMT_I:   enc_word = {imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
      FMT_ISH: enc_word = {bus.funct7, imm[4:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
      FMT_S:   enc_word = {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], bus.opcode};
      FMT_B:   enc_word = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                           imm[4:1], imm[11], bus.opcode};
      FMT_U:   enc_word = {imm[31:12], bus.rd, bus.opcode};
      FMT_J:   enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, bus.opcode};
      default: enc_word = NOP_WORD;
    endcase
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push  = bus.in_valid && !full;
  assign pop   = bus.out_ready && !empty;

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_instr = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign bus.out_addr  = out_addr_q;

  // clear wins over push and pop: no write, no pop, no address step.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    out_addr_d = out_addr_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      out_addr_d = ADDR_W'(BASE_ADDR);
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[PTR_W-1:0]] = enc_word;
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
      end
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + (PTR_W+1)'(1);
        out_addr_d = out_addr_q + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      out_addr_q <= ADDR_W'(BASE_ADDR);
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      out_addr_q <= out_addr_d;
      mem_q      <= mem_d;
    end
  end

`ifdef ENC_IMM_CHECK_EN
  localparam logic signed [N-1:0] I_MIN  = N'(-2048);
  localparam logic signed [N-1:0] I_MAX  = N'(2047);
  localparam logic signed [N-1:0] SH_MAX = N'(31);
  localparam logic signed [N-1:0] B_MIN  = N'(-4096);
  localparam logic signed [N-1:0] B_MAX  = N'(4094);
  localparam logic signed [N-1:0] J_MIN  = N'(-1048576);
  localparam logic signed [N-1:0] J_MAX  = N'(1048574);

  logic signed [N-1:0] imm_s;
  logic                imm_bad;
  logic                err_imm_q, err_imm_d;

  assign imm_s = $signed(imm);

  always_comb begin
    imm_bad = 1'b0;
    case (bus.fmt)
      FMT_I, FMT_S: imm_bad = (imm_s < I_MIN) || (imm_s > I_MAX);
      FMT_ISH:      imm_bad = imm[N-1] || (imm_s > SH_MAX);
      FMT_B:        imm_bad = (imm_s < B_MIN) || (imm_s > B_MAX) || imm[0];
      FMT_J:        imm_bad = (imm_s < J_MIN) || (imm_s > J_MAX) || imm[0];
      FMT_U:        imm_bad = (imm[11:0] != 12'd0);
      default:      imm_bad = 1'b0;
    endcase
  end

  always_comb begin
    err_imm_d = err_imm_q | (push & imm_bad);
    if (clear) err_imm_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_imm_q <= 1'b0;
    else        err_imm_q <= err_imm_d;
  end

  assign err_imm = err_imm_q;
`endif
endmodule
